multi_cycle_cpu: RTL and testbench
==================================

# multi_cycle_cpu

Multi-cycle MIPS-subset processor. It is the successor to the single-cycle core. One unified memory port with a req/ready handshake serves both instruction fetch and data access. A per-instruction state machine sequences FETCH, DECODE, EXEC, MEM and WB, so slow memory simply stretches the instruction. The block sits at the top of the CPU hierarchy and connects directly to a shared instruction/data memory model.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, width of mem_addr; the byte address is truncated to its low ADDR_W bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  byte address; memory ignores bits [1:0]
- mem_wdata  out  32  store data; valid while mem_req && mem_we
- mem_rdata  in  32  read data; sampled in the mem_ready cycle
- mem_ready  in  1  completes the current request in this cycle
- instruction  out  32  instruction register (IR)
- pcOut  out  32  current PC
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- halted  out  1  core stopped (only with the trap feature)

## Operation
- Supported ISA: R-type add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A), addi, lw, sw, beq, bne, j.
- Register file: 32x32. $0 reads 0; writes to $0 are discarded.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE: latch A=rs and B=rt; compute branch target = PC+4 + (sext(imm16)<<2). Next state:
  - j: PC<={PC[31:28], imm26, 2'b00}, retire, go to FETCH.
  - beq/bne, R-type, addi, lw, sw: go to EXEC.
- EXEC: ALU computes on A and B (R-type, beq/bne) or on A and sext(imm) (addi/lw/sw). Next state:
  - beq/bne: if taken (zero, or not-zero for bne), PC<=target; retire; go to FETCH.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=sw.
  - On mem_ready, sw: retire, go to FETCH.
  - On mem_ready, lw: MDR<=mem_rdata, go to WB.
- WB: write the destination (rd for R-type, rt for addi/lw) with ALUOut or MDR; retire; go to FETCH.
- Arithmetic: all results are 32-bit wrap-around with no overflow trap. slt is a signed compare. The PC adder wraps at 2^32.
- Unknown opcode or funct: see Configuration.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pcOut=RESET_PC; instruction, mem_addr and mem_wdata = 0.
  - mem_req, mem_we, retire, halted = 0.
  - All registers = 0; state=FETCH.
  - mem_req rises on the first clk edge after release.
- Handshake:
  - mem_req/mem_addr/mem_we/mem_wdata are registered and held stable until the cycle in which mem_ready=1 is sampled.
  - mem_req drops the following cycle. There is no back-to-back request without at least one non-request cycle.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory (ready in the first req cycle), counting from the first FETCH cycle:
  - j: 2 cycles
  - beq/bne: 3 cycles
  - R-type/addi/sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle adds one cycle.
- Reset asserted mid-transaction: mem_req drops asynchronously and no register write occurs.
- retire is high for exactly one cycle, coincident with the register, PC or store commit.

## Configuration
- MULTI_CYCLE_CPU_TRAP_EN defined: an unknown opcode or funct in DECODE moves to the HALT state.
  - halted=1, retire=0, no further memory requests.
  - PC stays at faulting PC+4.
  - Exit only via reset.
- Undefined: an unknown instruction executes as a NOP.
  - Sequence is DECODE to FETCH with retire=1, no register write.
  - halted is tied to 0.

## Structure
- multi_cycle_cpu_pkg holds:
  - opcode and funct constants
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - 3-bit ALU op encoding
  - RESET_PC default
- One sub-module, cpu_reg_file: 2 asynchronous read ports, 1 synchronous write port, $0 hardwired to zero, asynchronous active-low clear.
- ALU and control FSM are inline in multi_cycle_cpu.

## Test plan
- Reset with RESET_PC=32'h100, then release → first request is mem_addr=0x100, mem_we=0; pcOut=0x100 during reset.
- Zero-wait memory; program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 → $3=12; retire pulses at cycles 4, 8, 12.
- sw $3,8($0) then lw $4,8($0), with mem_ready delayed 3 cycles per request → write request addr=8, wdata=12, held stable for 4 cycles; $4=12; lw takes 8 cycles.
- beq $1,$1,-1 at 0x20 → PC returns to 0x20 after 3 cycles; bne $1,$1,-1 falls through to 0x24.
- j 0x40 at 0x3C → next fetch addr 0x100, 2-cycle instruction; addi $0,$0,9 → $0 stays 0.
- Opcode 0x3F: with MULTI_CYCLE_CPU_TRAP_EN, halted=1 and mem_req stays 0 for 20 cycles; without the macro, retire pulses and the fetch continues at PC+4. Asserting rst mid-fetch drops mem_req in the same cycle.

Source files
------------

// File: rtl/multi_cycle_cpu_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset core.
// Opcodes, funct codes, FSM states and the ALU op encoding.
package multi_cycle_cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } aluOp_t;

  function automatic logic [31:0] aluCompute(
    input aluOp_t      op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] res;
    unique case (op)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {31'd0, $signed(a) < $signed(b)};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multi_cycle_cpu_reg_file.sv
// 32x32 register file: two async read ports, one sync write port.
// $0 reads as zero and ignores writes; async active-low clear.
module cpu_reg_file
  import multi_cycle_cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddrA,
  input  logic [REG_ADDR_W-1:0] raddrB,
  output logic [31:0]           rdataA,
  output logic [31:0]           rdataB,
  input  logic                  wen,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [31:0]           wdata
);

  logic [31:0] regs [0:31];

  assign rdataA = (raddrA == '0) ? '0 : regs[raddrA];
  assign rdataB = (raddrB == '0) ? '0 : regs[raddrB];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core on one req/ready memory port.
// MULTI_CYCLE_CPU_TRAP_EN: unknown instructions halt instead of NOP.
module multi_cycle_cpu
  import multi_cycle_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instruction,
  output logic [31:0]       pcOut,
  output logic              retire,
  output logic              halted
);

  state_t state, stateNext;

  logic [31:0] pc, pcNext, ir;
  logic [31:0] regA, regB, aluOut, mdr, target;
  logic [31:0] rdataA, rdataB, immExt;
  logic [31:0] aluB, aluResult, wbData;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wbAddr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic isR, isAddi, isLw, isSw;
  logic isBeq, isBne, isJ;
  logic fnKnown, isKnown, taken;
  logic reqDone, reqStart, rfWe;
  aluOp_t aluOp;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];
  assign imm26  = ir[25:0];
  assign immExt = {{16{imm16[15]}}, imm16};

  assign instruction = ir;
  assign pcOut       = pc;

  always_comb begin
    {isR, isAddi, isLw, isSw} = '0;
    {isBeq, isBne, isJ} = '0;
    unique case (1'b1)
      opcode == OP_RTYPE: isR    = 1'b1;
      opcode == OP_ADDI:  isAddi = 1'b1;
      opcode == OP_LW:    isLw   = 1'b1;
      opcode == OP_SW:    isSw   = 1'b1;
      opcode == OP_BEQ:   isBeq  = 1'b1;
      opcode == OP_BNE:   isBne  = 1'b1;
      opcode == OP_J:     isJ    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aluOp   = ALU_ADD;
    fnKnown = 1'b0;
    if (isR) begin
      fnKnown = 1'b1;
      unique case (funct)
        FN_ADD:  aluOp = ALU_ADD;
        FN_SUB:  aluOp = ALU_SUB;
        FN_AND:  aluOp = ALU_AND;
        FN_OR:   aluOp = ALU_OR;
        FN_SLT:  aluOp = ALU_SLT;
        default: fnKnown = 1'b0;
      endcase
    end else if (isBeq || isBne) begin
      aluOp = ALU_SUB;
    end
  end

  assign isKnown = isR ? fnKnown :
    (isAddi | isLw | isSw | isBeq | isBne | isJ);

  assign aluB = (isR | isBeq | isBne) ? regB : immExt;
  assign aluResult = aluCompute(aluOp, regA, aluB);
  assign taken = (isBeq & (aluResult == '0)) |
                 (isBne & (aluResult != '0));

  assign wbAddr = isR ? rd : rt;
  assign wbData = isLw ? mdr : aluOut;

  assign reqDone = mem_req & mem_ready;

  cpu_reg_file u_regs (
    .clk    (clk),
    .rst    (rst),
    .raddrA (rs),
    .raddrB (rt),
    .rdataA (rdataA),
    .rdataB (rdataB),
    .wen    (rfWe),
    .waddr  (wbAddr),
    .wdata  (wbData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      FETCH:
        if (reqDone) stateNext = DECODE;
      DECODE:
        if (!isKnown)
`ifdef MULTI_CYCLE_CPU_TRAP_EN
          stateNext = HALT;
`else
          stateNext = FETCH;
`endif
        else if (isJ) stateNext = FETCH;
        else          stateNext = EXEC;
      EXEC:
        if (isBeq || isBne)   stateNext = FETCH;
        else if (isLw || isSw) stateNext = MEM;
        else                  stateNext = WB;
      MEM:
        if (reqDone) stateNext = isSw ? FETCH : WB;
      WB:
        stateNext = FETCH;
      HALT:
        stateNext = HALT;
      default:
        stateNext = FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    rfWe   = 1'b0;
    pcNext = pc;
    unique case (state)
      FETCH:
        if (reqDone) pcNext = pc + 32'd4;
      DECODE: begin
        if (isJ) pcNext = {pc[31:28], imm26, 2'b00};
`ifdef MULTI_CYCLE_CPU_TRAP_EN
        retire = isJ;
`else
        retire = isJ | ~isKnown;
`endif
      end
      EXEC:
        if (isBeq || isBne) begin
          retire = 1'b1;
          if (taken) pcNext = target;
        end
      MEM:
        retire = reqDone & isSw;
      WB: begin
        retire = 1'b1;
        rfWe   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTI_CYCLE_CPU_TRAP_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      regA   <= '0;
      regB   <= '0;
      aluOut <= '0;
      mdr    <= '0;
      target <= '0;
    end else begin
      pc <= pcNext;
      if (state == FETCH && reqDone) ir <= mem_rdata;
      if (state == DECODE) begin
        regA   <= rdataA;
        regB   <= rdataB;
        target <= pc + {immExt[29:0], 2'b00};
      end
      if (state == EXEC) aluOut <= aluResult;
      if (state == MEM && reqDone && isLw) mdr <= mem_rdata;
    end
  end

  // A request launches only from an idle port, so one idle cycle
  // always separates two consecutive transactions.
  assign reqStart = ~mem_req &
    (stateNext == FETCH || stateNext == MEM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (reqDone) begin
      mem_req <= 1'b0;
    end else if (reqStart) begin
      mem_req <= 1'b1;
      if (stateNext == MEM) begin
        mem_we    <= isSw;
        mem_addr  <= aluResult[ADDR_W-1:0];
        mem_wdata <= isSw ? regB : '0;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= pcNext[ADDR_W-1:0];
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu with a small unified memory model.
// Build with MULTI_CYCLE_CPU_TRAP_EN to exercise the halt path.
module tb_multi_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] instruction, pcOut;
  logic        retire, halted;

  always #5 clk = ~clk;

  multi_cycle_cpu #(
    .RESET_PC (32'h100),
    .ADDR_W   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .instruction (instruction),
    .pcOut       (pcOut),
    .retire      (retire),
    .halted      (halted)
  );

  logic [31:0] mem [0:127];
  int  wcnt = 0;
  int  dataWait = 0;
  bit  stallAll = 1'b0;

  // addresses below 0x20 are data and see dataWait wait states
  assign mem_ready = mem_req && !stallAll &&
    ((mem_addr >= 32'h20) || (wcnt == dataWait));
  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int retQ[$];
  int reqCycQ[$];
  int reqAddrQ[$];
  int holdCnt = 0;
  bit prevReq = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (retire) retQ.push_back(cyc);
      if (mem_req && !prevReq) begin
        reqCycQ.push_back(cyc);
        reqAddrQ.push_back(int'(mem_addr));
      end
      if (mem_req && mem_we && mem_addr == 32'h8 &&
          mem_wdata == 32'd12)
        holdCnt++;
    end
    prevReq = mem_req;
  end

  int nChecks = 0;
  int nPass = 0;

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  function automatic logic [31:0] enR(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enI(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enJ(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    retQ.delete();
    reqCycQ.delete();
    reqAddrQ.delete();
    holdCnt = 0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clearMem();
    mem[64] = enI(6'h08, 5'd0, 5'd1, 16'd5);
    rst = 1'b0;
    @(negedge clk);
    nChecks++;
    if (pcOut !== 32'h100) $display("FAIL reset_pc: got %h want 100", pcOut);
    else nPass++;
    nChecks++;
    if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req);
    else nPass++;
    nChecks++;
    if (instruction !== 32'h0) $display("FAIL reset_ir: got %h want 0", instruction);
    else nPass++;
    nChecks++;
    if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr);
    else nPass++;
    nChecks++;
    if ({retire, halted, mem_we} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {retire, halted, mem_we});
    else nPass++;
    rst = 1'b1;
    #1;
    nChecks++;
    if (mem_req !== 1'b0) $display("FAIL release_req: got %b want 0", mem_req);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if ({mem_req, mem_we} !== 2'b10)
      $display("FAIL first_req: got %b want 10", {mem_req, mem_we});
    else nPass++;
    nChecks++;
    if (mem_addr !== 32'h100) $display("FAIL first_addr: got %h want 100", mem_addr);
    else nPass++;
  endtask

  task automatic test_alu();
    clearMem();
    dataWait = 0;
    mem[64] = enI(6'h08, 5'd0, 5'd1, 16'd5);
    mem[65] = enI(6'h08, 5'd0, 5'd2, 16'd7);
    mem[66] = enR(5'd1, 5'd2, 5'd3, 6'h20);
    mem[67] = enR(5'd1, 5'd2, 5'd4, 6'h22);
    mem[68] = enR(5'd1, 5'd2, 5'd5, 6'h24);
    mem[69] = enR(5'd1, 5'd2, 5'd6, 6'h25);
    mem[70] = enR(5'd4, 5'd1, 5'd7, 6'h2A);
    mem[71] = enI(6'h08, 5'd0, 5'd0, 16'd9);
    mem[72] = enI(6'h2B, 5'd0, 5'd3, 16'd0);
    mem[73] = enI(6'h2B, 5'd0, 5'd4, 16'd4);
    mem[74] = enI(6'h2B, 5'd0, 5'd5, 16'd8);
    mem[75] = enI(6'h2B, 5'd0, 5'd6, 16'd12);
    mem[76] = enI(6'h2B, 5'd0, 5'd7, 16'd16);
    mem[77] = enI(6'h2B, 5'd0, 5'd0, 16'd20);
    mem[78] = enR(5'd1, 5'd4, 5'd8, 6'h2A);
    mem[79] = enI(6'h2B, 5'd0, 5'd8, 16'd24);
    mem[80] = enI(6'h04, 5'd0, 5'd0, 16'hFFFF);
    mem[5] = 32'hDEAD;
    mem[6] = 32'hDEAD;
    doReset();
    runCycles(150);
    nChecks++;
    if (at(retQ, 0) - at(reqCycQ, 0) + 1 !== 4)
      $display("FAIL retire1: got %0d want 4", at(retQ, 0) - at(reqCycQ, 0) + 1);
    else nPass++;
    nChecks++;
    if (at(retQ, 1) - at(reqCycQ, 0) + 1 !== 8)
      $display("FAIL retire2: got %0d want 8", at(retQ, 1) - at(reqCycQ, 0) + 1);
    else nPass++;
    nChecks++;
    if (at(retQ, 2) - at(reqCycQ, 0) + 1 !== 12)
      $display("FAIL retire3: got %0d want 12", at(retQ, 2) - at(reqCycQ, 0) + 1);
    else nPass++;
    nChecks++;
    if (mem[0] !== 32'd12) $display("FAIL add: got %h want c", mem[0]);
    else nPass++;
    nChecks++;
    if (mem[1] !== 32'hFFFF_FFFE) $display("FAIL sub: got %h want fffffffe", mem[1]);
    else nPass++;
    nChecks++;
    if (mem[2] !== 32'd5) $display("FAIL and: got %h want 5", mem[2]);
    else nPass++;
    nChecks++;
    if (mem[3] !== 32'd7) $display("FAIL or: got %h want 7", mem[3]);
    else nPass++;
    nChecks++;
    if (mem[4] !== 32'd1) $display("FAIL slt_neg: got %h want 1", mem[4]);
    else nPass++;
    nChecks++;
    if (mem[5] !== 32'd0) $display("FAIL zero_reg: got %h want 0", mem[5]);
    else nPass++;
    nChecks++;
    if (mem[6] !== 32'd0) $display("FAIL slt_pos: got %h want 0", mem[6]);
    else nPass++;
  endtask

  task automatic test_mem_wait();
    clearMem();
    dataWait = 3;
    mem[64] = enI(6'h08, 5'd0, 5'd3, 16'd12);
    mem[65] = enI(6'h2B, 5'd0, 5'd3, 16'd8);
    mem[66] = enI(6'h23, 5'd0, 5'd4, 16'd8);
    mem[67] = enI(6'h2B, 5'd0, 5'd4, 16'd12);
    mem[68] = enI(6'h04, 5'd0, 5'd0, 16'hFFFF);
    mem[3] = 32'hDEAD;
    doReset();
    runCycles(80);
    nChecks++;
    if (holdCnt !== 4) $display("FAIL sw_hold: got %0d want 4", holdCnt);
    else nPass++;
    nChecks++;
    if (at(retQ, 1) - at(reqCycQ, 1) + 1 !== 7)
      $display("FAIL sw_cycles: got %0d want 7", at(retQ, 1) - at(reqCycQ, 1) + 1);
    else nPass++;
    nChecks++;
    if (at(retQ, 2) - at(reqCycQ, 3) + 1 !== 8)
      $display("FAIL lw_cycles: got %0d want 8", at(retQ, 2) - at(reqCycQ, 3) + 1);
    else nPass++;
    nChecks++;
    if (mem[2] !== 32'd12) $display("FAIL sw_data: got %h want c", mem[2]);
    else nPass++;
    nChecks++;
    if (mem[3] !== 32'd12) $display("FAIL lw_data: got %h want c", mem[3]);
    else nPass++;
    dataWait = 0;
  endtask

  task automatic test_branch();
    int expA [6] = '{32'h100, 32'h104, 32'h20, 32'h24, 32'h3C, 32'h100};
    clearMem();
    mem[64] = enI(6'h08, 5'd0, 5'd1, 16'd1);
    mem[65] = enJ(26'h8);
    mem[8]  = enI(6'h05, 5'd1, 5'd1, 16'hFFFF);
    mem[9]  = enJ(26'hF);
    mem[15] = enJ(26'h40);
    doReset();
    runCycles(40);
    for (int i = 1; i < 6; i++) begin
      nChecks++;
      if (at(reqAddrQ, i) !== expA[i])
        $display("FAIL fetch_addr%0d: got %h want %h", i, at(reqAddrQ, i), expA[i]);
      else nPass++;
    end
    nChecks++;
    if (at(retQ, 2) - at(reqCycQ, 2) + 1 !== 3)
      $display("FAIL bne_cycles: got %0d want 3", at(retQ, 2) - at(reqCycQ, 2) + 1);
    else nPass++;
    nChecks++;
    if (at(retQ, 4) - at(reqCycQ, 4) + 1 !== 2)
      $display("FAIL j_cycles: got %0d want 2", at(retQ, 4) - at(reqCycQ, 4) + 1);
    else nPass++;

    mem[8] = enI(6'h04, 5'd1, 5'd1, 16'hFFFF);
    doReset();
    runCycles(30);
    for (int i = 2; i < 5; i++) begin
      nChecks++;
      if (at(reqAddrQ, i) !== 32'h20)
        $display("FAIL beq_addr%0d: got %h want 20", i, at(reqAddrQ, i));
      else nPass++;
    end
    nChecks++;
    if (at(retQ, 2) - at(reqCycQ, 2) + 1 !== 3)
      $display("FAIL beq_cycles: got %0d want 3", at(retQ, 2) - at(reqCycQ, 2) + 1);
    else nPass++;
  endtask

  task automatic test_unknown();
    int reqSeen;
    clearMem();
    mem[64] = enI(6'h08, 5'd0, 5'd1, 16'd3);
    mem[65] = 32'hFC00_0000;
    mem[66] = enI(6'h2B, 5'd0, 5'd1, 16'd0);
    mem[67] = enI(6'h04, 5'd0, 5'd0, 16'hFFFF);
    mem[0] = 32'hDEAD;
    doReset();
    runCycles(40);
`ifdef MULTI_CYCLE_CPU_TRAP_EN
    nChecks++;
    if (halted !== 1'b1) $display("FAIL trap_halted: got %b want 1", halted);
    else nPass++;
    nChecks++;
    if (pcOut !== 32'h108) $display("FAIL trap_pc: got %h want 108", pcOut);
    else nPass++;
    nChecks++;
    if (retQ.size() !== 1) $display("FAIL trap_retires: got %0d want 1", retQ.size());
    else nPass++;
    reqSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqSeen++;
    end
    nChecks++;
    if (reqSeen !== 0) $display("FAIL trap_req: got %0d want 0", reqSeen);
    else nPass++;
`else
    reqSeen = 0;
    nChecks++;
    if (halted !== 1'b0) $display("FAIL nop_halted: got %b want 0", halted);
    else nPass++;
    nChecks++;
    if (at(retQ, 1) - at(reqCycQ, 1) + 1 !== 2)
      $display("FAIL nop_cycles: got %0d want 2", at(retQ, 1) - at(reqCycQ, 1) + 1);
    else nPass++;
    nChecks++;
    if (at(reqAddrQ, 2) !== 32'h108)
      $display("FAIL nop_next: got %h want 108", at(reqAddrQ, 2));
    else nPass++;
    nChecks++;
    if (mem[0] !== 32'd3) $display("FAIL nop_store: got %h want 3", mem[0]);
    else nPass++;
`endif
  endtask

  task automatic test_reset_midfetch();
    clearMem();
    stallAll = 1'b1;
    doReset();
    runCycles(3);
    nChecks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h100})
      $display("FAIL stall_req: got %b/%h want 1/100", mem_req, mem_addr);
    else nPass++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    nChecks++;
    if (mem_req !== 1'b0) $display("FAIL async_drop: got %b want 0", mem_req);
    else nPass++;
    nChecks++;
    if (pcOut !== 32'h100) $display("FAIL async_pc: got %h want 100", pcOut);
    else nPass++;
    stallAll = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_unknown();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
